// File: rtl/regfile_wb_if.sv
// Writeback request channel into the regfile write queue: address/data with valid/ready.
interface regfile_wb_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          valid;
  logic          ready;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue in front of the 32x32 regfile write port.
// Pending, uncommitted values are forwarded onto both read ports.
module regfile_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  regfile_wb_if.slave                  wb,
  input  logic                         drain_en,
  output logic                         RW,
  output logic [AW-1:0]                DA,
  output logic [DW-1:0]                D_data,
  input  logic [AW-1:0]                AA,
  input  logic [AW-1:0]                BA,
  input  logic [DW-1:0]                rf_A_data,
  input  logic [DW-1:0]                rf_B_data,
  output logic [DW-1:0]                A_data,
  output logic [DW-1:0]                B_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          push;
  logic          pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign wb.ready = !full;
  assign push     = wb.valid && wb.ready;
  // A reset cycle must not let the head entry reach the regfile.
  assign pop      = !empty && drain_en && !reset;

  assign RW     = pop;
  assign DA     = pop ? mem_addr[head] : '0;
  assign D_data = pop ? mem_data[head] : '0;

  // Pointers, occupancy and entry storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem_addr[tail] <= wb.addr;
        mem_data[tail] <= wb.data;
        tail           <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Walk entries oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx    = '0;
    A_data = rf_A_data;
    B_data = rf_B_data;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        if (mem_addr[idx] == AA) A_data = mem_data[idx];
        if (mem_addr[idx] == BA) B_data = mem_data[idx];
      end
    end
  end

endmodule
